// File: rtl/sub_pkg.sv
// Shared types and limits for the serial subtractor family.
package sub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sub_state_t;

    localparam int unsigned SUB_MAX_WIDTH = 64;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_n.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell reused LSB first,
// with start/busy/done handshake and registered diff/bout/ovf.
module serial_sub_n
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > SUB_MAX_WIDTH) begin : g_width_check
        $error("serial_sub_n: WIDTH out of range");
    end

    sub_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             cell_d;
    logic             cell_bout;

    full_sub_cell u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = cell_bout;
                res_d  = {cell_d, res_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // On the last bit the shifters' LSBs hold the operand sign bits
                    // and cell_d is the result sign bit.
                    state_d = IDLE;
                    cnt_d   = '0;
                    diff_d  = {cell_d, res_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
                    ovf_d   = (a_sh_q[0] != b_sh_q[0]) & (cell_d != a_sh_q[0]);
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub_n.sv
// Self-checking bench for serial_sub_n at WIDTH 8, 5 and 2 with a result scoreboard.
module tb_serial_sub_n;

    typedef struct {
        logic [63:0] diff;
        logic        bout;
        logic        ovf;
        longint      acc;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    longint cyc = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8, ovf8;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic       start5 = 1'b0, bin5 = 1'b0, busy5, done5, bout5, ovf5;
    logic [4:0] a5 = '0, b5 = '0, diff5;
    logic       start2 = 1'b0, bin2 = 1'b0, busy2, done2, bout2, ovf2;
    logic [1:0] a2 = '0, b2 = '0, diff2;

    serial_sub_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );
    serial_sub_n #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .a(a5), .b(b5), .bin(bin5),
        .busy(busy5), .done(done5), .diff(diff5), .bout(bout5), .ovf(ovf5)
    );
    serial_sub_n #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .ovf(ovf2)
    );

    exp_t q8[$], q5[$], q2[$];
    exp_t e8, e5, e2;
    int dcnt8 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int w, input longint av, input longint bv, input bit bi);
        exp_t   e;
        longint m  = (longint'(1) << w) - 1;
        longint sa = av[w-1] ? av - (longint'(1) << w) : av;
        longint sb = bv[w-1] ? bv - (longint'(1) << w) : bv;
        longint r  = sa - sb - longint'(bi);
        e.diff = 64'((av - bv - longint'(bi)) & m);
        e.bout = (av < bv + longint'(bi));
        e.ovf  = (r > (longint'(1) << (w - 1)) - 1) || (r < -(longint'(1) << (w - 1)));
        e.acc  = 0;
        return e;
    endfunction

    task automatic score(input string name, input exp_t e, input logic [63:0] d,
                         input logic bo, input logic ov, input logic bs);
        check({name, "_diff"}, d, e.diff);
        check({name, "_bout"}, 64'(bo), 64'(e.bout));
        check({name, "_ovf"}, 64'(ov), 64'(e.ovf));
        check({name, "_latency"}, 64'(cyc - e.acc), 64'(0)
              + ((name == "w8") ? 64'd8 : (name == "w5") ? 64'd5 : 64'd2));
        check({name, "_busy_with_done"}, 64'(bs), 64'd0);
    endtask

    always @(negedge clk) begin
        if (done8) begin
            dcnt8++;
            if (q8.size() == 0) check("w8_spurious_done", 64'd1, 64'd0);
            else begin e8 = q8.pop_front(); score("w8", e8, 64'(diff8), bout8, ovf8, busy8); end
        end
        if (done5) begin
            if (q5.size() == 0) check("w5_spurious_done", 64'd1, 64'd0);
            else begin e5 = q5.pop_front(); score("w5", e5, 64'(diff5), bout5, ovf5, busy5); end
        end
        if (done2) begin
            if (q2.size() == 0) check("w2_spurious_done", 64'd1, 64'd0);
            else begin e2 = q2.pop_front(); score("w2", e2, 64'(diff2), bout2, ovf2, busy2); end
        end
    end

    function automatic logic busy_of(input int w);
        return (w == 8) ? busy8 : (w == 5) ? busy5 : busy2;
    endfunction

    function automatic int qsize(input int w);
        return (w == 8) ? q8.size() : (w == 5) ? q5.size() : q2.size();
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input int w, input logic [63:0] av, input logic [63:0] bv,
                         input logic bi, input exp_t e_in);
        exp_t e = e_in;
        int   n = 0;
        while (busy_of(w) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check($sformatf("w%0d_idle_timeout", w), 64'd1, 64'd0);
        e.acc = cyc + 1;
        case (w)
            8: begin a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi; start8 = 1'b1; q8.push_back(e); end
            5: begin a5 = av[4:0]; b5 = bv[4:0]; bin5 = bi; start5 = 1'b1; q5.push_back(e); end
            default: begin a2 = av[1:0]; b2 = bv[1:0]; bin2 = bi; start2 = 1'b1; q2.push_back(e); end
        endcase
        @(negedge clk);
        start8 = 1'b0;
        start5 = 1'b0;
        start2 = 1'b0;
        a8 = 8'hA5; b8 = 8'h5A; bin8 = ~bin8;
    endtask

    task automatic drain(input int w);
        int n = 0;
        while (qsize(w) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("w%0d_drain", w), 64'(qsize(w)), 64'd0);
        @(negedge clk);
    endtask

    vec_t vecs[9];
    exp_t ex;
    int   c0;

    initial begin
        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'h7F, 8'h00, 1'b1, 8'h7E, 1'b0, 1'b0};
        vecs[8] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_done8", 64'(done8), 64'd0);
        check("rst_diff8", 64'(diff8), 64'd0);
        check("rst_bout8", 64'(bout8), 64'd0);
        check("rst_ovf8", 64'(ovf8), 64'd0);
        check("rst_busy5", 64'(busy5), 64'd0);
        check("rst_diff5", 64'(diff5), 64'd0);
        check("rst_busy2", 64'(busy2), 64'd0);
        check("rst_diff2", 64'(diff2), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            ex.diff = 64'(vecs[i].diff);
            ex.bout = vecs[i].bout;
            ex.ovf  = vecs[i].ovf;
            ex.acc  = 0;
            issue(8, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].bin, ex);
        end
        drain(8);

        // start held high: accepts at the first IDLE cycle after each completion
        c0 = dcnt8;
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        ex = '{64'h0F, 1'b0, 1'b0, cyc + 1};
        q8.push_back(ex);
        @(negedge clk);
        a8 = 8'h20; b8 = 8'h02;
        ex = '{64'h1E, 1'b0, 1'b0, q8[0].acc + 9};
        q8.push_back(ex);
        while (cyc < ex.acc) @(negedge clk);
        start8 = 1'b0;
        drain(8);
        repeat (10) @(negedge clk);
        check("held_start_done_count", 64'(dcnt8 - c0), 64'd2);

        // reset during RUN aborts without done
        ex = model(8, 64'h40, 64'h11, 1'b0);
        issue(8, 64'h40, 64'h11, 1'b0, ex);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy8), 64'd0);
        check("midrst_done", 64'(done8), 64'd0);
        check("midrst_diff", 64'(diff8), 64'd0);
        check("midrst_bout", 64'(bout8), 64'd0);
        check("midrst_ovf", 64'(ovf8), 64'd0);
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        c0 = dcnt8;
        repeat (12) @(negedge clk);
        check("midrst_no_done", 64'(dcnt8 - c0), 64'd0);
        ex = '{64'h74, 1'b0, 1'b1, 0};
        issue(8, 64'h9C, 64'h27, 1'b1, ex);
        drain(8);

        for (int av = 0; av < 32; av++)
            for (int bv = 0; bv < 32; bv++)
                for (int bi = 0; bi < 2; bi++)
                    issue(5, 64'(av), 64'(bv), bi[0], model(5, av, bv, bi[0]));
        drain(5);

        for (int av = 0; av < 4; av++)
            for (int bv = 0; bv < 4; bv++)
                for (int bi = 0; bi < 2; bi++)
                    issue(2, 64'(av), 64'(bv), bi[0], model(2, av, bv, bi[0]));
        drain(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
